muldiv_ctrl: RTL and testbench

//  Multi-cycle multiply/divide sequencer and HI/LO register owner for the P7 pipeline.

---
 rtl/muldiv_ctrl_pkg.sv | 39 +++
 rtl/muldiv_ctrl_md_arith.sv | 65 ++++++
 rtl/muldiv_ctrl.sv | 158 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips_defs
// Description : Shared multiply/divide definitions for the P7 pipeline:
//               3-bit MD operation codes, sequencer state encodings and
//               small opcode-classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_defs;

    // MD operation codes carried on md_op
    localparam logic [2:0] MD_OP_MULT  = 3'b000;
    localparam logic [2:0] MD_OP_MULTU = 3'b001;
    localparam logic [2:0] MD_OP_DIV   = 3'b010;
    localparam logic [2:0] MD_OP_DIVU  = 3'b011;
    localparam logic [2:0] MD_OP_MTHI  = 3'b100;
    localparam logic [2:0] MD_OP_MTLO  = 3'b101;

    // Sequencer state encodings
    localparam logic [0:0] MD_ST_IDLE = 1'b0;
    localparam logic [0:0] MD_ST_BUSY = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = MD_ST_IDLE,
        ST_BUSY = MD_ST_BUSY
    } md_state_e;

    // Multi-cycle ops: the ones that occupy the unit and can cause a stall
    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MD_OP_MULT) || (op == MD_OP_MULTU) ||
               (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_ctrl_md_arith.sv
`default_nettype none
// ============================================================================
// Module      : md_arith
// Description : Combinational MD datapath. Produces the 64-bit product and
//               32-bit quotient/remainder of the latched operands.
// Ports       : op        in  3   latched MD op (selects signedness)
//               a         in  32  latched rs operand (multiplicand/dividend)
//               b         in  32  latched rt operand (multiplier/divisor)
//               prod      out 64  a*b, signed or unsigned per op
//               quo       out 32  a/b, truncated toward zero
//               rem       out 32  a%b, sign follows the dividend
//               div_zero  out 1   divisor is zero
// Revision    : 1.0 - initial release
// ============================================================================
module md_arith
    import mips_defs::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] prod,
    output logic [31:0] quo,
    output logic [31:0] rem,
    output logic        div_zero
);

    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic        w_div_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;

    // Extending to 64 bits first makes the low 64 bits of the product
    // correct for both signed and unsigned operands.
    assign w_a_ext = (op == MD_OP_MULT) ? {{32{a[31]}}, a} : {32'd0, a};
    assign w_b_ext = (op == MD_OP_MULT) ? {{32{b[31]}}, b} : {32'd0, b};
    assign prod    = w_a_ext * w_b_ext;

    // Signed division on magnitudes, then restore signs. 0x80000000 / -1
    // falls out naturally: magnitude 0x80000000 re-negates to itself.
    assign w_div_signed = (op == MD_OP_DIV);
    assign w_a_neg      = w_div_signed & a[31];
    assign w_b_neg      = w_div_signed & b[31];
    assign w_a_mag      = w_a_neg ? (~a + 32'd1) : a;
    assign w_b_mag      = w_b_neg ? (~b + 32'd1) : b;
    assign div_zero     = (b == 32'd0);

    always_comb begin
        w_q_mag = 32'd0;
        w_r_mag = 32'd0;
        if (!div_zero) begin
            w_q_mag = w_a_mag / w_b_mag;
            w_r_mag = w_a_mag % w_b_mag;
        end
    end

    assign quo = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign rem = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl
// Description : Multi-cycle multiply/divide sequencer and HI/LO owner for the
//               P7 pipeline. Models fixed MD latency and raises the D-stage
//               stall on MD hazards.
// Ports       : clk       in  1   system clock, rising edge
//               reset     in  1   asynchronous active-high reset
//               start     in  1   E-stage instruction is an MD op
//               md_op     in  3   MD operation code
//               rs_val    in  32  forwarded rs operand
//               rt_val    in  32  forwarded rt operand
//               flush     in  1   E-stage instruction must not commit
//               md_use_d  in  1   D-stage instruction uses the MD unit
//               busy      out 1   operation in flight
//               stall     out 1   freeze F/D, bubble into E
//               hi        out 32  HI register
//               lo        out 32  LO register
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_ctrl
    import mips_defs::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    input  logic        md_use_d,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_MULT_CNT = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_CNT  = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    md_state_e          r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic [2:0]         r_op,    w_op_nxt;
    logic [31:0]        r_rs,    w_rs_nxt;
    logic [31:0]        r_rt,    w_rt_nxt;
    logic [31:0]        r_hi,    w_hi_nxt;
    logic [31:0]        r_lo,    w_lo_nxt;

    logic               w_accept;
    logic [63:0]        w_prod;
    logic [31:0]        w_quo;
    logic [31:0]        w_rem;
    logic               w_div_zero;

    md_arith u_md_arith (
        .op       (r_op),
        .a        (r_rs),
        .b        (r_rt),
        .prod     (w_prod),
        .quo      (w_quo),
        .rem      (w_rem),
        .div_zero (w_div_zero)
    );

    // A flushed E-stage instruction never commits, so it is never accepted.
    assign w_accept = start & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= 3'd0;
            r_rs    <= 32'd0;
            r_rt    <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_rs    <= w_rs_nxt;
            r_rt    <= w_rt_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_rs_nxt    = r_rs;
        w_rt_nxt    = r_rt;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (md_op)
                        MD_OP_MULT, MD_OP_MULTU: begin
                            w_op_nxt    = md_op;
                            w_rs_nxt    = rs_val;
                            w_rt_nxt    = rt_val;
                            w_cnt_nxt   = c_MULT_CNT;
                            w_state_nxt = ST_BUSY;
                        end
                        MD_OP_DIV, MD_OP_DIVU: begin
                            w_op_nxt    = md_op;
                            w_rs_nxt    = rs_val;
                            w_rt_nxt    = rt_val;
                            w_cnt_nxt   = c_DIV_CNT;
                            w_state_nxt = ST_BUSY;
                        end
                        MD_OP_MTHI: w_hi_nxt = rs_val;
                        MD_OP_MTLO: w_lo_nxt = rs_val;
                        default: ;  // undefined codes are dropped
                    endcase
                end
            end
            ST_BUSY: begin
                // start is ignored here; the pipeline stall keeps it away.
                if (r_cnt == c_CNT_ONE) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                    if (is_div_op(r_op)) begin
                        // Divide by zero burns the full latency but leaves HI/LO alone.
                        if (!w_div_zero) begin
                            w_hi_nxt = w_rem;
                            w_lo_nxt = w_quo;
                        end
                    end else begin
                        w_hi_nxt = w_prod[63:32];
                        w_lo_nxt = w_prod[31:0];
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy  = (r_state == ST_BUSY);
    // Stall in the issue cycle too, so the D-stage MD instruction cannot
    // slip into E while the new long op is being accepted.
    assign stall = md_use_d & (busy | (w_accept & is_long_op(md_op)));
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_ctrl
// Description : Self-checking bench for muldiv_ctrl. A table of MD ops with
//               expected busy length and HI/LO results is pushed to a
//               scoreboard on issue and compared when the op retires; hand
//               sequences cover stall, flush and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;
    import mips_defs::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        md_use_d;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    vec_t vecs[13];
    exp_t sb[$];

    muldiv_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .flush    (flush),
        .md_use_d (md_use_d),
        .busy     (busy),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Count busy cycles from the first negedge after the accepting edge.
    task automatic count_busy(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int cycles,
                          input logic [31:0] e_hi, input logic [31:0] e_lo);
        exp_t e;
        int   cyc;
        sb.push_back('{cycles, e_hi, e_lo});
        issue(op, a, b);
        count_busy(cyc);
        e = sb.pop_front();
        check({tag, "_busy"}, 32'(cyc), 32'(e.cycles));
        check({tag, "_hi"}, hi, e.hi);
        check({tag, "_lo"}, lo, e.lo);
    endtask

    initial begin
        int cyc;

        vecs[0]  = '{MD_OP_MULT,  32'hFFFFFFFD, 32'd5,        5,  32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1]  = '{MD_OP_MULTU, 32'hFFFFFFFF, 32'd2,        5,  32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{MD_OP_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{MD_OP_DIVU,  32'd7,        32'd2,        10, 32'h00000001, 32'h00000003};
        vecs[4]  = '{MD_OP_MTHI,  32'h00000011, 32'd0,        0,  32'h00000011, 32'h00000003};
        vecs[5]  = '{MD_OP_MTLO,  32'h00000022, 32'd0,        0,  32'h00000011, 32'h00000022};
        vecs[6]  = '{MD_OP_DIVU,  32'd5,        32'd0,        10, 32'h00000011, 32'h00000022};
        vecs[7]  = '{MD_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        vecs[8]  = '{MD_OP_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{MD_OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 5,  32'h3FFFFFFF, 32'h00000001};
        vecs[10] = '{MD_OP_MULTU, 32'h00010000, 32'h00010000, 5,  32'h00000001, 32'h00000000};
        vecs[11] = '{3'b110,      32'hDEADBEEF, 32'd3,        0,  32'h00000001, 32'h00000000};
        vecs[12] = '{MD_OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 10, 32'hFFFFFFFF, 32'h00000003};

        reset    = 1'b1;
        start    = 1'b0;
        md_op    = 3'd0;
        rs_val   = 32'd0;
        rt_val   = 32'd0;
        flush    = 1'b0;
        md_use_d = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        check("reset_busy",  32'(busy),  32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_hi",    hi,         32'd0);
        check("reset_lo",    lo,         32'd0);

        for (int i = 0; i < 13; i++) begin
            run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
                   vecs[i].cycles, vecs[i].hi, vecs[i].lo);
        end

        // Stall: raised combinationally in the issue cycle and held while busy.
        @(negedge clk);
        start = 1'b1; md_op = MD_OP_MULT; rs_val = 32'd3; rt_val = 32'd4; md_use_d = 1'b1;
        #1;
        check("stall_issue", 32'(stall), 32'd1);
        check("stall_issue_busy", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("stall_busy", 32'(stall), 32'd1);
        count_busy(cyc);
        check("stall_mult_busy", 32'(cyc), 32'd5);
        check("stall_release", 32'(stall), 32'd0);
        check("stall_mult_lo", lo, 32'd12);
        md_op = MD_OP_MTHI;
        start = 1'b1;
        #1;
        check("stall_mthi", 32'(stall), 32'd0);
        start = 1'b0;
        md_use_d = 1'b0;

        // start with flush in the same cycle is dropped entirely.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; md_op = MD_OP_DIV; rs_val = 32'd100; rt_val = 32'd3;
        md_use_d = 1'b1;
        #1;
        check("flush_stall", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0; md_use_d = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_hi", hi, 32'd0);
        check("flush_lo", lo, 32'd12);

        // Flush while busy belongs to a younger instruction; the op completes.
        sb.push_back('{10, 32'd1, 32'd33});
        issue(MD_OP_DIVU, 32'd100, 32'd3);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        count_busy(cyc);
        begin
            exp_t e;
            e = sb.pop_front();
            check("flushbusy_busy", 32'(cyc + 1), 32'(e.cycles));
            check("flushbusy_hi", hi, e.hi);
            check("flushbusy_lo", lo, e.lo);
        end

        // Asynchronous reset in the middle of a divide.
        issue(MD_OP_DIV, 32'd20, 32'd3);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("post_rst_mtlo", MD_OP_MTLO, 32'h0000ABCD, 32'd0, 0, 32'd0, 32'h0000ABCD);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
